addf_serial_seq: RTL and testbench



---
 rtl/addf_serial_seq.sv | 129 ++++++++++++
 tb/tb_addf_serial_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addf_serial_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell plus a carry flop.
// Operands are accepted over a valid/ready handshake, processed LSB-first at one
// bit per clock, and the sum, carry-out and signed overflow are returned over a
// second valid/ready handshake.
module addf_serial_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             OVF,
    output logic             BUSY
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic            r_carry;
    logic            r_cin_msb;
    logic [CntW-1:0] r_cnt;

    logic w_load;
    logic w_last;
    logic w_s;
    logic w_co;

    // The single full-adder cell shared by every bit position.
    assign w_s  = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_co = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

    assign w_load = (r_state == StIdle) & IN_VALID & ~RST;
    assign w_last = (r_state == StRun) & (r_cnt == CntLast);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_next = r_state;
        IN_READY     = 1'b0;
        OUT_VALID    = 1'b0;
        BUSY         = 1'b0;
        SUM          = '0;
        CO           = 1'b0;
        OVF          = 1'b0;
        unique case (r_state)
            StIdle: begin
                IN_READY = ~RST;
                if (w_load) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                BUSY = 1'b1;
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                BUSY      = 1'b1;
                OUT_VALID = 1'b1;
                SUM       = r_sum_sh;
                CO        = r_carry;
                // Overflow when the carry into the MSB differs from the carry out of it.
                OVF       = r_cin_msb ^ r_carry;
                if (OUT_READY) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Operand load on the input handshake, then one bit per clock while running.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_cnt     <= '0;
        end else if (w_load) begin
            // Subtraction is A + ~B + ~borrow_in.
            r_a_sh  <= A;
            r_b_sh  <= SUB ? ~B : B;
            r_carry <= CI ^ SUB;
            r_cnt   <= '0;
        end else if (r_state == StRun) begin
            r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_carry  <= w_co;
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_cin_msb <= r_carry;
            end
        end
    end

endmodule

// File: tb/tb_addf_serial_seq.sv
// Self-checking bench for addf_serial_seq: directed vector table plus
// hand-written sequences for backpressure, reset and back-to-back streaming.
module tb_addf_serial_seq;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CI;
    logic         SUB;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] SUM;
    logic         CO;
    logic         OVF;
    logic         BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    addf_serial_seq #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CI        (CI),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .CO        (CO),
        .OVF       (OVF),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: word-level add, written independently of the serial datapath.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic ci, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   t;
        logic         ovf;
        bb  = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci ^ sub};
        ovf = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return {ovf, t[W], t[W-1:0]};
    endfunction

    // Start one op, wait for the result, check it and the latency, then consume it.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub, input logic [W-1:0] e_sum,
                          input logic e_co, input logic e_ovf);
        int n;
        n = 0;
        while (!IN_READY && n < 50) begin
            tick();
            n++;
        end
        A        = a;
        B        = b;
        CI       = ci;
        SUB      = sub;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        A        = ~a;
        B        = ~b;
        n        = 0;
        while (!OUT_VALID && n < 100) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, n, W);
        chk({nm, " SUM"}, SUM, e_sum);
        chk({nm, " CO"}, CO, e_co);
        chk({nm, " OVF"}, OVF, e_ovf);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    initial begin
        logic [W-1:0] bp_sum;
        logic [W-1:0] ra[3];
        logic [W-1:0] rb[3];
        logic         rci[3];
        logic         rsub[3];
        logic [W+1:0] exp_r;
        int           ink;
        int           outk;
        int           last_t;
        int           cyc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        A         = '0;
        B         = '0;
        CI        = 1'b0;
        SUB       = 1'b0;
        tick();
        tick();
        chk("reset OUT_VALID", OUT_VALID, 1'b0);
        chk("reset BUSY", BUSY, 1'b0);
        chk("reset SUM", SUM, 8'h00);
        chk("reset CO", CO, 1'b0);
        chk("reset OVF", OVF, 1'b0);
        chk("reset IN_READY while RST", IN_READY, 1'b0);
        RST = 1'b0;
        #1;
        chk("IN_READY after reset", IN_READY, 1'b1);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub,
                   vecs[i].sum, vecs[i].co, vecs[i].ovf);
        end

        // Backpressure: hold result for 5 cycles while inputs wiggle.
        A        = 8'h5A;
        B        = 8'h3C;
        CI       = 1'b0;
        SUB      = 1'b0;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        cyc      = 0;
        while (!OUT_VALID && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("bp reach DONE", OUT_VALID, 1'b1);
        bp_sum = SUM;
        chk("bp SUM", bp_sum, 8'h96);
        for (int i = 0; i < 5; i++) begin
            A        = 8'(i * 37);
            B        = ~A;
            IN_VALID = i[0];
            SUB      = ~i[0];
            tick();
            chk($sformatf("bp hold%0d SUM", i), SUM, 8'h96);
            chk($sformatf("bp hold%0d CO", i), CO, 1'b0);
            chk($sformatf("bp hold%0d OVF", i), OVF, 1'b1);
            chk($sformatf("bp hold%0d OUT_VALID", i), OUT_VALID, 1'b1);
            chk($sformatf("bp hold%0d IN_READY", i), IN_READY, 1'b0);
        end
        // IN_VALID high during output handshake must not start a new op.
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        tick();
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        chk("bp release OUT_VALID", OUT_VALID, 1'b0);
        chk("bp release BUSY", BUSY, 1'b0);
        chk("bp release IN_READY", IN_READY, 1'b1);

        // OUT_READY outside DONE and RST with IN_VALID in IDLE.
        RST      = 1'b1;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        RST      = 1'b0;
        tick();
        chk("rst+valid BUSY", BUSY, 1'b0);

        // Reset during the 4th RUN cycle.
        A        = 8'h33;
        B        = 8'h44;
        CI       = 1'b0;
        SUB      = 1'b0;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        tick();
        chk("mid-run BUSY before reset", BUSY, 1'b1);
        RST = 1'b1;
        tick();
        chk("mid-run reset OUT_VALID", OUT_VALID, 1'b0);
        chk("mid-run reset BUSY", BUSY, 1'b0);
        chk("mid-run reset SUM", SUM, 8'h00);
        RST = 1'b0;
        #1;
        chk("mid-run reset IN_READY", IN_READY, 1'b1);
        run_op("post-reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        // Back-to-back with both handshakes held high.
        for (int i = 0; i < 3; i++) begin
            ra[i]   = 8'($urandom);
            rb[i]   = 8'($urandom);
            rci[i]  = 1'($urandom_range(0, 1));
            rsub[i] = 1'($urandom_range(0, 1));
        end
        ink       = 0;
        outk      = 0;
        last_t    = 0;
        cyc       = 0;
        OUT_READY = 1'b1;
        while (outk < 3 && cyc < 200) begin
            if (OUT_VALID) begin
                exp_r = ref_op(ra[outk], rb[outk], rci[outk], rsub[outk]);
                chk($sformatf("b2b%0d SUM", outk), SUM, exp_r[W-1:0]);
                chk($sformatf("b2b%0d CO", outk), CO, exp_r[W]);
                chk($sformatf("b2b%0d OVF", outk), OVF, exp_r[W+1]);
                if (outk > 0) begin
                    chk($sformatf("b2b%0d gap", outk), cyc - last_t, W + 2);
                end
                last_t = cyc;
                outk++;
            end
            if (IN_READY && ink < 3) begin
                A        = ra[ink];
                B        = rb[ink];
                CI       = rci[ink];
                SUB      = rsub[ink];
                IN_VALID = 1'b1;
                ink++;
            end else if (IN_READY) begin
                IN_VALID = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("b2b results seen", outk, 3);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
